// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch-request generator with a one-entry redirect buffer that holds
// a branch target arriving while the fetch cannot advance.
module pc_fetch_unit #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC  = ADDR_W'(32'h00000000),
  parameter int unsigned          INST_BYTES = 4,
  parameter int unsigned          STALL_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_address_i,
  input  logic                flush_i,
  input  logic [ADDR_W-1:0]   new_pc_i,
  input  logic                imem_ack_i,
  output logic [ADDR_W-1:0]   pc,
  output logic                ce,
  output logic                redirect_pend_o,
  output logic                align_err_o
);

  localparam logic StOff = 1'b0;
  localparam logic StRun = 1'b1;

  localparam logic [ADDR_W-1:0] LowMask = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] PcInc   = ADDR_W'(INST_BYTES);

  logic              state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] buf_q, buf_d;
  logic              err_q, err_d;

  logic              advance;
  logic [ADDR_W-1:0] flush_tgt, branch_tgt;
  logic              flush_mis, branch_mis;
  logic              stall_unused;

  // Only bit 0 of the stall vector is meaningful to fetch.
  assign stall_unused = ^stall;

  assign advance    = (state_q == StRun) && ce_q && !stall[0] && imem_ack_i;
  assign flush_tgt  = new_pc_i & ~LowMask;
  assign flush_mis  = |(new_pc_i & LowMask);
  assign branch_tgt = branch_target_address_i & ~LowMask;
  assign branch_mis = |(branch_target_address_i & LowMask);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ce_d    = ce_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    if (state_q == StOff) begin
      // First fetch address is RESET_VEC itself, so pc is left untouched here.
      state_d = StRun;
      ce_d    = 1'b1;
    end else if (flush_i) begin
      pc_d   = flush_tgt;
      pend_d = 1'b0;
      err_d  = flush_mis;
    end else if (branch_flag_i) begin
      err_d = branch_mis;
      if (advance) begin
        pc_d   = branch_tgt;
        pend_d = 1'b0;
      end else begin
        buf_d  = branch_tgt;
        pend_d = 1'b1;
      end
    end else if (advance) begin
      if (pend_q) begin
        // Buffered target was aligned (and flagged) when it was stored.
        pc_d   = buf_q;
        pend_d = 1'b0;
      end else begin
        pc_d = pc_q + PcInc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StOff;
      pc_q    <= RESET_VEC;
      ce_q    <= 1'b0;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  assign pc              = pc_q;
  assign ce              = ce_q;
  assign redirect_pend_o = pend_q;
  assign align_err_o     = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic, all checked
// against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam int unsigned ADDR_W     = 32;
  localparam logic [31:0] RESET_VEC  = 32'h00000000;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned STALL_W    = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               branch_flag_i;
  logic [31:0]        branch_target_address_i;
  logic               flush_i;
  logic [31:0]        new_pc_i;
  logic               imem_ack_i;
  logic [31:0]        pc;
  logic               ce;
  logic               redirect_pend_o;
  logic               align_err_o;

  pc_fetch_unit #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (RESET_VEC),
    .INST_BYTES(INST_BYTES),
    .STALL_W   (STALL_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall                  (stall),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .flush_i                (flush_i),
    .new_pc_i               (new_pc_i),
    .imem_ack_i             (imem_ack_i),
    .pc                     (pc),
    .ce                     (ce),
    .redirect_pend_o        (redirect_pend_o),
    .align_err_o            (align_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_ce, m_pend, m_err;
  logic [31:0] m_buf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] t);
    return (t / INST_BYTES) * INST_BYTES;
  endfunction

  // Applies the fetch rules for one clock edge to the model.
  task automatic model_edge();
    bit adv;
    if (!rst) begin
      m_run = 0; m_pc = RESET_VEC; m_ce = 0; m_pend = 0; m_buf = '0; m_err = 0;
    end else if (!m_run) begin
      m_run = 1; m_ce = 1; m_err = 0;
    end else begin
      adv   = m_ce && !stall[0] && imem_ack_i;
      m_err = 0;
      if (flush_i) begin
        m_pc   = align(new_pc_i);
        m_pend = 0;
        m_err  = (new_pc_i % INST_BYTES) != 0;
      end else if (branch_flag_i) begin
        m_err = (branch_target_address_i % INST_BYTES) != 0;
        if (adv) begin
          m_pc   = align(branch_target_address_i);
          m_pend = 0;
        end else begin
          m_buf  = align(branch_target_address_i);
          m_pend = 1;
        end
      end else if (adv) begin
        if (m_pend) begin
          m_pc   = m_buf;
          m_pend = 0;
        end else begin
          m_pc = m_pc + INST_BYTES;  // 32-bit wrap is implicit
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".pc"},   pc,              m_pc);
    check({tag, ".ce"},   ce,              32'(m_ce));
    check({tag, ".pend"}, redirect_pend_o, 32'(m_pend));
    check({tag, ".aerr"}, align_err_o,     32'(m_err));
  endtask

  task automatic drive(input bit r, input logic [5:0] st, input bit ack,
                       input bit br, input logic [31:0] bt,
                       input bit fl, input logic [31:0] np);
    rst = r; stall = st; imem_ack_i = ack;
    branch_flag_i = br; branch_target_address_i = bt;
    flush_i = fl; new_pc_i = np;
  endtask

  initial begin
    m_run = 0; m_pc = RESET_VEC; m_ce = 0; m_pend = 0; m_buf = '0; m_err = 0;
    drive(0, 6'd0, 1, 0, 0, 0, 0);
    step("reset");
    check("reset.pc_abs", pc, 32'h0);
    check("reset.ce_abs", ce, 32'h0);

    // Reset release: first fetch at RESET_VEC, then sequential
    drive(1, 6'd0, 1, 0, 0, 0, 0);
    step("rel0"); check("rel0.pc_abs", pc, 32'h0); check("rel0.ce_abs", ce, 32'h1);
    step("rel1"); check("rel1.pc_abs", pc, 32'h4);
    step("rel2"); check("rel2.pc_abs", pc, 32'h8);

    // Branch during stall, last branch wins
    drive(1, 6'd1, 1, 1, 32'h100, 0, 0);
    step("bst0"); check("bst0.pc_abs", pc, 32'h8); check("bst0.pend_abs", redirect_pend_o, 1);
    drive(1, 6'd1, 1, 1, 32'h200, 0, 0);
    step("bst1"); check("bst1.pc_abs", pc, 32'h8);
    drive(1, 6'd0, 1, 0, 0, 0, 0);
    step("bst2"); check("bst2.pc_abs", pc, 32'h200); check("bst2.pend_abs", redirect_pend_o, 0);

    // Flush overrides stall and pending redirect
    drive(1, 6'd1, 0, 1, 32'h300, 0, 0);
    step("fl0"); check("fl0.pend_abs", redirect_pend_o, 1);
    drive(1, 6'd1, 0, 0, 0, 1, 32'h80);
    step("fl1"); check("fl1.pc_abs", pc, 32'h80); check("fl1.pend_abs", redirect_pend_o, 0);

    // Misaligned branch in an advance cycle
    drive(1, 6'd0, 1, 1, 32'h103, 0, 0);
    step("mis0"); check("mis0.pc_abs", pc, 32'h100); check("mis0.aerr_abs", align_err_o, 1);
    drive(1, 6'd0, 1, 0, 0, 0, 0);
    step("mis1"); check("mis1.aerr_abs", align_err_o, 0); check("mis1.pc_abs", pc, 32'h104);

    // Wrap and ack gating
    drive(1, 6'd0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    step("wr0"); check("wr0.pc_abs", pc, 32'hFFFF_FFFC);
    drive(1, 6'd0, 1, 0, 0, 0, 0);
    step("wr1"); check("wr1.pc_abs", pc, 32'h0);
    drive(1, 6'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("ack0");
      check("ack0.pc_abs", pc, 32'h0);
    end

    // Reset mid-operation with a redirect pending
    drive(1, 6'd1, 1, 1, 32'h440, 0, 0);
    step("rm0"); check("rm0.pend_abs", redirect_pend_o, 1);
    drive(0, 6'd1, 1, 1, 32'h500, 1, 32'h600);
    step("rm1");
    check("rm1.pc_abs", pc, RESET_VEC);
    check("rm1.ce_abs", ce, 0);
    check("rm1.pend_abs", redirect_pend_o, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 99) >= 2),
            6'($urandom()) & ($urandom_range(0, 2) == 0 ? 6'h3F : 6'h3E),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 25), $urandom(),
            ($urandom_range(0, 99) < 8), $urandom());
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
